// File: rtl/window_stream_packer_if.sv
// -----------------------------------------------------------------------------
// window_stream_packer_if
// Bundles the sample stream (input side) and the packed window stream (output
// side) of window_stream_packer.
//
// Optional feature macro: WIN_PACK_RUNSUM_EN adds the signed win_sum signal.
//
// Signals:
//   in_data    signed sample from the producer
//   in_valid   in_data valid
//   in_ready   packer can accept a sample
//   win_data   packed window, lane i at [DATA_W*i +: DATA_W], lane 0 oldest
//   win_valid  win_data valid
//   win_ready  consumer accepts the window
//   fill_level samples held in the shift register, saturating at WIN_LEN
//   win_sum    (WIN_PACK_RUNSUM_EN) wrapping sum of the emitted window
//
// Modports:
//   slave  - the packer (receives samples, drives windows)
//   master - the environment around it (drives samples, consumes windows)
// -----------------------------------------------------------------------------
interface window_stream_packer_if #(
   parameter int DATA_W  = 32,
   parameter int WIN_LEN = 8
);
   logic signed [DATA_W-1:0]  in_data;
   logic                      in_valid;
   logic                      in_ready;
   logic [WIN_LEN*DATA_W-1:0] win_data;
   logic                      win_valid;
   logic                      win_ready;
   logic [6:0]                fill_level;
`ifdef WIN_PACK_RUNSUM_EN
   logic signed [DATA_W-1:0]  win_sum;

   modport slave (
      input  in_data, in_valid, win_ready,
      output in_ready, win_data, win_valid, fill_level, win_sum
   );
   modport master (
      output in_data, in_valid, win_ready,
      input  in_ready, win_data, win_valid, fill_level, win_sum
   );
`else
   modport slave (
      input  in_data, in_valid, win_ready,
      output in_ready, win_data, win_valid, fill_level
   );
   modport master (
      output in_data, in_valid, win_ready,
      input  in_ready, win_data, win_valid, fill_level
   );
`endif
endinterface

// File: rtl/window_stream_packer.sv
// -----------------------------------------------------------------------------
// window_stream_packer
// Turns a stream of signed samples into packed sliding windows of WIN_LEN
// samples for the window-sum adder tree. Valid/ready on both sides, a
// configurable stride between windows once full, and a synchronous flush.
//
// Optional feature macro: WIN_PACK_RUNSUM_EN -- keeps an incremental running
// sum of the window and registers it as win_sum alongside win_data.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   i_clear  synchronous flush of all window state (priority over accept)
//   if_win   window_stream_packer_if.slave (sample in, window out, fill_level)
//
// Parameters:
//   DATA_W   sample width (signed two's complement)
//   WIN_LEN  samples per window, 2..64
//   STRIDE   accepts between consecutive windows once full, 1..65535
// -----------------------------------------------------------------------------
module window_stream_packer #(
   parameter int DATA_W  = 32,
   parameter int WIN_LEN = 8,
   parameter int STRIDE  = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_clear,
   window_stream_packer_if.slave if_win
);
   localparam int                CNT_W    = (STRIDE > 1) ? $clog2(STRIDE) : 1;
   localparam logic [6:0]        FULL     = 7'(WIN_LEN);
   localparam logic [6:0]        FULL_M1  = 7'(WIN_LEN - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STRIDE - 1);

   // fill_level counts up to WIN_LEN and then sticks there
   function automatic logic [6:0] sat_fill(input logic [6:0] f);
      return (f == FULL) ? f : f + 7'd1;
   endfunction

   logic [WIN_LEN-1:0][DATA_W-1:0] r_lane;
   logic [WIN_LEN-1:0][DATA_W-1:0] r_win_data;
   logic                           r_win_valid;
   logic [6:0]                     r_fill;
   logic [CNT_W-1:0]               r_stride_cnt;

   logic                           w_in_ready;
   logic                           w_accept;
   logic                           w_full;
   logic                           w_fill_done;
   logic                           w_emit;
   logic [CNT_W-1:0]               w_cnt_nxt;
   logic [WIN_LEN-1:0][DATA_W-1:0] w_shift;

   assign w_in_ready  = !r_win_valid || if_win.win_ready;
   assign w_accept    = if_win.in_valid && w_in_ready;
   assign w_full      = (r_fill == FULL);
   assign w_fill_done = (r_fill == FULL_M1);
   // Lane 0 is evicted, the new sample enters at the top (newest) lane
   assign w_shift     = {if_win.in_data, r_lane[WIN_LEN-1:1]};

   // The filling accept emits and restarts the stride count; afterwards every
   // STRIDE-th accept emits.
   assign w_emit = w_accept && (w_fill_done || (w_full && (r_stride_cnt == CNT_LAST)));

   always_comb begin
      w_cnt_nxt = r_stride_cnt;
      if (w_fill_done) begin
         w_cnt_nxt = '0;
      end else if (w_full) begin
         w_cnt_nxt = (r_stride_cnt == CNT_LAST) ? '0 : r_stride_cnt + 1'b1;
      end
   end

`ifdef WIN_PACK_RUNSUM_EN
   function automatic logic signed [DATA_W-1:0] wrap_acc(
      input logic signed [DATA_W-1:0] acc,
      input logic signed [DATA_W-1:0] add,
      input logic signed [DATA_W-1:0] sub
   );
      return acc + add - sub;
   endfunction

   logic signed [DATA_W-1:0] r_sum;
   logic signed [DATA_W-1:0] r_win_sum;
   logic signed [DATA_W-1:0] w_evicted;
   logic signed [DATA_W-1:0] w_sum_nxt;

   // Before the window is full lane 0 is still a zero, but using an explicit
   // zero keeps the sum independent of how the register was cleared.
   assign w_evicted = w_full ? $signed(r_lane[0]) : '0;
   assign w_sum_nxt = wrap_acc(r_sum, if_win.in_data, w_evicted);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sum     <= '0;
         r_win_sum <= '0;
      end else if (i_clear) begin
         r_sum     <= '0;
         r_win_sum <= '0;
      end else begin
         if (w_accept) begin
            r_sum <= w_sum_nxt;
         end
         if (w_emit) begin
            r_win_sum <= w_sum_nxt;
         end
      end
   end

   assign if_win.win_sum = r_win_sum;
`endif

   // ---- stage boundary: shift register / window output register ----
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_lane       <= '0;
         r_win_data   <= '0;
         r_win_valid  <= 1'b0;
         r_fill       <= '0;
         r_stride_cnt <= '0;
      end else if (i_clear) begin
         // A pending window is discarded; win_data simply holds its last value
         r_lane       <= '0;
         r_win_valid  <= 1'b0;
         r_fill       <= '0;
         r_stride_cnt <= '0;
      end else begin
         if (w_accept) begin
            r_lane       <= w_shift;
            r_fill       <= sat_fill(r_fill);
            r_stride_cnt <= w_cnt_nxt;
         end
         // An emission on the transfer edge reloads back-to-back
         if (w_emit) begin
            r_win_data  <= w_shift;
            r_win_valid <= 1'b1;
         end else if (if_win.win_ready) begin
            r_win_valid <= 1'b0;
         end
      end
   end

   assign if_win.in_ready   = w_in_ready;
   assign if_win.win_data   = r_win_data;
   assign if_win.win_valid  = r_win_valid;
   assign if_win.fill_level = r_fill;

endmodule

// File: tb/tb_window_stream_packer.sv
// -----------------------------------------------------------------------------
// tb_window_stream_packer
// Two packers (STRIDE=1 and STRIDE=4, WIN_LEN=8) share one sample stream and
// clear/reset; each has its own win_ready. A reference model keeps the list of
// samples accepted since the last flush and derives each expected window as the
// last WIN_LEN of them, emitted when (count-WIN_LEN) is a multiple of STRIDE.
// -----------------------------------------------------------------------------
module tb_window_stream_packer;
   localparam int DW = 32;
   localparam int WL = 8;
   localparam int SA = 1;
   localparam int SB = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic clear = 1'b0;

   always #5 clk = ~clk;

   window_stream_packer_if #(.DATA_W(DW), .WIN_LEN(WL)) if_a ();
   window_stream_packer_if #(.DATA_W(DW), .WIN_LEN(WL)) if_b ();

   window_stream_packer #(.DATA_W(DW), .WIN_LEN(WL), .STRIDE(SA)) u_dut_a (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_clear (clear),
      .if_win  (if_a)
   );

   window_stream_packer #(.DATA_W(DW), .WIN_LEN(WL), .STRIDE(SB)) u_dut_b (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_clear (clear),
      .if_win  (if_b)
   );

   int               n_tests = 0;
   int               n_fail  = 0;
   int               b_win_cnt = 0;
   logic [31:0]      seq [2][$];
   logic             exp_vld [2];
   logic [WL*DW-1:0] exp_win [2];
   logic [DW-1:0]    exp_sum [2];

   task automatic chk(input string tag, input logic [WL*DW-1:0] obs, input logic [WL*DW-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int fill_of(input int k);
      return (seq[k].size() < WL) ? seq[k].size() : WL;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         seq[k].delete();
         exp_vld[k] = 1'b0;
         exp_win[k] = '0;
         exp_sum[k] = '0;
      end
   endtask

   task automatic model_step(input int k, input logic acc, input logic wr,
                             input logic clr, input logic [31:0] d);
      int   n;
      int   s;
      logic emit;
      s    = (k == 0) ? SA : SB;
      emit = 1'b0;
      n    = 0;
      if (clr) begin
         seq[k].delete();
         exp_vld[k] = 1'b0;
         exp_sum[k] = '0;
      end else begin
         if (acc) begin
            seq[k].push_back(d);
            n = seq[k].size();
            if (n >= WL && ((n - WL) % s) == 0) begin
               emit       = 1'b1;
               exp_win[k] = '0;
               exp_sum[k] = '0;
               for (int j = 0; j < WL; j++) begin
                  exp_win[k][DW*j +: DW] = seq[k][n-WL+j];
                  exp_sum[k]             = exp_sum[k] + seq[k][n-WL+j];
               end
            end
         end
         if (emit) exp_vld[k] = 1'b1;
         else if (wr) exp_vld[k] = 1'b0;
      end
   endtask

   task automatic check_outputs();
      chk("a_win_valid",  if_a.win_valid,  exp_vld[0]);
      chk("a_fill_level", if_a.fill_level, fill_of(0));
      chk("a_win_data",   if_a.win_data,   exp_win[0]);
      chk("b_win_valid",  if_b.win_valid,  exp_vld[1]);
      chk("b_fill_level", if_b.fill_level, fill_of(1));
      chk("b_win_data",   if_b.win_data,   exp_win[1]);
`ifdef WIN_PACK_RUNSUM_EN
      chk("a_win_sum", if_a.win_sum, exp_sum[0]);
      chk("b_win_sum", if_b.win_sum, exp_sum[1]);
`endif
   endtask

   // One clock: drive at the falling edge, check in_ready before the rising
   // edge, advance the model and check outputs just after it.
   task automatic cyc(input logic v, input logic [31:0] d, input logic ra,
                      input logic rb, input logic clr);
      logic acc_a;
      logic acc_b;
      @(negedge clk);
      if_a.in_valid  = v;
      if_b.in_valid  = v;
      if_a.in_data   = d;
      if_b.in_data   = d;
      if_a.win_ready = ra;
      if_b.win_ready = rb;
      clear          = clr;
      #1;
      chk("a_in_ready", if_a.in_ready, !exp_vld[0] || ra);
      chk("b_in_ready", if_b.in_ready, !exp_vld[1] || rb);
      acc_a = v && (!exp_vld[0] || ra);
      acc_b = v && (!exp_vld[1] || rb);
      @(posedge clk);
      #1;
      model_step(0, acc_a, ra, clr, d);
      model_step(1, acc_b, rb, clr, d);
      check_outputs();
      if (if_b.win_valid === 1'b1) b_win_cnt++;
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2;
      rst_n         = 1'b0;
      if_a.in_valid = 1'b0;
      if_b.in_valid = 1'b0;
      clear         = 1'b0;
      model_reset();
      #1;
      check_outputs();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [31:0] rand_sample();
      case ($urandom % 5)
         0:       return 32'hFFFF_FFFF;
         1:       return 32'h7FFF_FFFF;
         2:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [WL*DW-1:0] held;
      if_a.in_valid  = 1'b0;
      if_b.in_valid  = 1'b0;
      if_a.in_data   = '0;
      if_b.in_data   = '0;
      if_a.win_ready = 1'b1;
      if_b.win_ready = 1'b1;
      model_reset();

      // Power-on reset
      #2;
      rst_n = 1'b0;
      #1;
      check_outputs();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Fill and stream 1..20 with both consumers ready
      b_win_cnt = 0;
      for (int i = 1; i <= 20; i++) begin
         cyc(1'b1, 32'(i), 1'b1, 1'b1, 1'b0);
         if (i == 7) chk("a_no_early_window", if_a.win_valid, 1'b0);
         if (i == 8) begin
            chk("a_first_lane0", if_a.win_data[31:0],    32'd1);
            chk("a_first_lane7", if_a.win_data[255:224], 32'd8);
`ifdef WIN_PACK_RUNSUM_EN
            chk("a_first_sum", if_a.win_sum, 32'd36);
`endif
         end
         if (i == 9) begin
            chk("a_second_lane0", if_a.win_data[31:0],    32'd2);
            chk("a_second_lane7", if_a.win_data[255:224], 32'd9);
`ifdef WIN_PACK_RUNSUM_EN
            chk("a_second_sum", if_a.win_sum, 32'd44);
`endif
         end
         if (i == 20) begin
            chk("b_last_lane0", if_b.win_data[31:0],    32'd13);
            chk("b_last_lane7", if_b.win_data[255:224], 32'd20);
         end
      end
      chk("b_window_count", b_win_cnt, 4);

      // Backpressure on A for 10 cycles while samples keep arriving
      held = if_a.win_data;
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, rand_sample(), 1'b0, 1'b1, 1'b0);
         chk("a_held_data", if_a.win_data, held);
      end
      cyc(1'b1, 32'h0000_0055, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 32'h0000_0056, 1'b1, 1'b1, 1'b0);

      // Flush, five samples, then flush together with a valid sample
      cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) cyc(1'b1, 32'(100 + i), 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1);
      chk("a_fill_after_clear", if_a.fill_level, 7'd0);
      for (int i = 0; i < 8; i++) cyc(1'b1, 32'(200 + i), 1'b1, 1'b1, 1'b0);
      chk("a_window_after_clear", if_a.win_data[31:0], 32'd200);

      // Signed wrap of the running sum
      cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) cyc(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
`ifdef WIN_PACK_RUNSUM_EN
      chk("a_sum_minus8", if_a.win_sum, 32'hFFFF_FFF8);
`endif
      cyc(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 32'h0000_0001, 1'b1, 1'b1, 1'b0);

      // Random traffic with random backpressure and occasional flushes
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom % 4) != 0, rand_sample(), ($urandom % 3) != 0,
             ($urandom % 3) != 0, ($urandom % 60) == 0);
      end

      // Asynchronous reset while A holds a stalled window
      cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) cyc(1'b1, 32'(300 + i), 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk("a_stalled_before_reset", if_a.win_valid, 1'b1);
      async_reset();
      for (int i = 0; i < 10; i++) cyc(1'b1, 32'(400 + i), 1'b1, 1'b1, 1'b0);
      chk("a_resume_lane0", if_a.win_data[31:0], 32'd402);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/window_stream_packer.md
Name: window_stream_packer

Overview:
- Producer side of the detection window-sum path: turns a stream of signed 32-bit samples into packed sliding windows of WIN_LEN samples.
- Output is the WIN_LEN*DATA_W-bit windowdata bus consumed by the combinational window-sum adder tree.
- Sits between the per-pixel feature stream and the window-sum stage.
- Adds valid/ready flow control on both sides, a configurable stride and a synchronous flush.

Parameters:
- DATA_W, 32, sample width in bits, signed two's complement.
- WIN_LEN, 8, samples per window; legal range 2..64.
- STRIDE, 1, accepted samples between consecutive windows once the window is full; legal range 1..65535.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush of all window state.
- in_data  in  DATA_W  input sample.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a sample.
- win_data  out  WIN_LEN*DATA_W  packed window; lane i at bits [DATA_W*i +: DATA_W]; lane 0 oldest, lane WIN_LEN-1 newest.
- win_valid  out  1  win_data valid.
- win_ready  in  1  consumer accepts the window.
- fill_level  out  7  samples currently held in the shift register, saturating at WIN_LEN.

Behaviour:
- Interface (decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: shift register 0, fill_level 0, stride counter 0, win_valid 0, win_data 0.
- Accept: a sample is accepted when in_valid && in_ready.
- in_ready = !win_valid || win_ready. This is combinational; no skid buffer.
- Shift on accept: lanes move down one place (lane i <= lane i+1) and lane WIN_LEN-1 <= in_data. The old lane 0 is evicted.
- Fill phase:
  - fill_level increments on each accept until it reaches WIN_LEN.
  - No window is emitted before fill_level reaches WIN_LEN.
- Emission:
  - The accept that brings fill_level to WIN_LEN emits the first window.
  - After that, a window is emitted on every STRIDE-th further accept. The stride counter counts 0..STRIDE-1 and wraps on each emission.
  - With STRIDE=1, every accept after fill emits.
- Emission latency: on the accepting edge, win_data is loaded with the post-shift register contents and win_valid is set. The window is therefore visible on the cycle after the accept.
- Output handshake:
  - The window transfers when win_valid && win_ready.
  - If no new emission occurs on that edge, win_valid clears. A new emission on the same edge keeps win_valid at 1 and loads the new window back-to-back.
  - While win_valid && !win_ready: win_data is held stable and in_ready=0. No sample is accepted, so no window is ever lost or overwritten.
- Throughput: 1 sample/cycle with STRIDE=1 and win_ready tied high.
- Arithmetic: samples are passed through bit-exact; no arithmetic in the data path.
- clear:
  - On the next edge, fill_level, the stride counter and win_valid are set to 0 and the shift register is zeroed.
  - clear has priority over a simultaneous accept (the sample is dropped) and over a pending window (the window is discarded).
  - in_ready follows the normal rule during clear.
- Reset mid-operation: all state returns to reset values immediately. The first window after release requires a full WIN_LEN new samples.

Optional Feature:
- Macro: WIN_PACK_RUNSUM_EN.
- When defined:
  - Adds output port win_sum, out, DATA_W wide, signed.
  - A running sum is kept incrementally: sum <= sum + in_data - evicted on each accept. evicted is the old lane 0 when fill_level == WIN_LEN, otherwise 0. Arithmetic is modulo 2^DATA_W.
  - win_sum is registered together with win_data and equals the wrapping sum of all WIN_LEN lanes of the emitted window, identical to the window-sum tree result.
  - Reset and clear zero both the running sum and win_sum.
- When undefined: no win_sum port and no sum logic.

Test Plan:
- Fill, STRIDE=1, win_ready=1: accept samples 1..8 → win_valid rises the cycle after the 8th accept with lane0=1 and lane7=8 (win_sum=36 if enabled). Sample 9 → lanes 2..9 (sum 44). No window is emitted before the 8th sample.
- Backpressure: hold win_ready=0 after the first window → in_ready=0 and win_data stays stable for 10 cycles. Raise win_ready → transfer completes, in_ready=1, and the next sample is accepted.
- STRIDE=4: stream samples 1..20 → exactly 4 windows, emitted after samples 8, 12, 16 and 20. The last window holds lanes 13..20.
- Signed wrap (RUNSUM_EN): feed eight samples of 0xFFFFFFFF → win_sum=0xFFFFFFF8 (-8). Then feed 0x7FFFFFFF and 1 → sums wrap modulo 2^32 and match a reference model.
- clear asserted with a simultaneous accept after 5 samples → fill_level=0 and the sample is dropped. The first window appears only after 8 new samples.
- Assert rst_n low while win_valid=1 and win_ready=0 → win_valid falls asynchronously, fill_level=0 and win_data=0. Normal operation resumes after release.
